load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: turns a MEM-stage access into one word-aligned bus transaction with
// lane-replicated store data, aligned/extended load data, and misalignment/timeout faults.
module load_store_unit #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             mem_req,
  input  logic             Mem_rw,
  input  logic [2:0]       size_type,
  input  logic [WIDTH-1:0] ALU_out,
  input  logic [WIDTH-1:0] Data_B,
  output logic             stall,
  output logic [WIDTH-1:0] load_data,
  output logic             done,
  output logic             misaligned,
  output logic             bus_err,
  output logic             bus_req,
  output logic             bus_we,
  output logic [WIDTH-1:0] bus_addr,
  output logic [WIDTH-1:0] bus_wdata,
  output logic [3:0]       bus_be,
  input  logic [WIDTH-1:0] bus_rdata,
  input  logic             bus_ack
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q;
  logic            rw_q;
  logic [2:0]      size_q;
  logic [1:0]      off_q;

  logic             fault;
  logic             timeout;
  logic [3:0]       be_sel;
  logic [WIDTH-1:0] wdata_sel;
  logic [WIDTH-1:0] load_ext;
  logic [WIDTH-1:0] rdata_sh;
  logic [7:0]       byte_v;
  logic [15:0]      half_v;

  assign timeout = (cnt_q == CntW'(TIMEOUT - 1));
  assign done    = (state_q == StDone);
  assign stall   = mem_req && (state_q != StDone);

  // Fault check on the live request operands, evaluated while IDLE.
  always_comb begin
    fault = 1'b0;
    unique case (size_type)
      3'b000, 3'b100: fault = 1'b0;
      3'b001, 3'b101: fault = ALU_out[0];
      3'b010:         fault = |ALU_out[1:0];
      default:        fault = 1'b1;
    endcase
    if (Mem_rw && size_type[2]) fault = 1'b1;
  end

  always_comb begin
    be_sel    = 4'b1111;
    wdata_sel = Data_B;
    if (Mem_rw) begin
      unique case (size_type[1:0])
        2'b00: begin
          be_sel    = 4'b0001 << ALU_out[1:0];
          wdata_sel = {4{Data_B[7:0]}};
        end
        2'b01: begin
          be_sel    = ALU_out[1] ? 4'b1100 : 4'b0011;
          wdata_sel = {2{Data_B[15:0]}};
        end
        default: begin
          be_sel    = 4'b1111;
          wdata_sel = Data_B;
        end
      endcase
    end
  end

  always_comb begin
    rdata_sh = bus_rdata >> {off_q, 3'b000};
    byte_v   = rdata_sh[7:0];
    half_v   = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    unique case (size_q)
      3'b000:  load_ext = {{(WIDTH-8){byte_v[7]}}, byte_v};
      3'b001:  load_ext = {{(WIDTH-16){half_v[15]}}, half_v};
      3'b100:  load_ext = {{(WIDTH-8){1'b0}}, byte_v};
      3'b101:  load_ext = {{(WIDTH-16){1'b0}}, half_v};
      default: load_ext = bus_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (mem_req) state_d = fault ? StDone : StBusy;
      StBusy:  if (bus_ack || timeout) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q      <= '0;
      rw_q       <= 1'b0;
      size_q     <= 3'b000;
      off_q      <= 2'b00;
      load_data  <= '0;
      misaligned <= 1'b0;
      bus_err    <= 1'b0;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      bus_be     <= 4'b0000;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (mem_req) begin
            rw_q   <= Mem_rw;
            size_q <= size_type;
            off_q  <= ALU_out[1:0];
            cnt_q  <= '0;
            if (fault) begin
              misaligned <= 1'b1;
              bus_err    <= 1'b0;
            end else begin
              bus_req   <= 1'b1;
              bus_we    <= Mem_rw;
              bus_addr  <= {ALU_out[WIDTH-1:2], 2'b00};
              bus_wdata <= wdata_sel;
              bus_be    <= be_sel;
            end
          end
        end
        StBusy: begin
          // An ack in the last counted cycle takes priority over the timeout.
          if (bus_ack) begin
            bus_req    <= 1'b0;
            misaligned <= 1'b0;
            bus_err    <= 1'b0;
            if (!rw_q) load_data <= load_ext;
          end else if (timeout) begin
            bus_req    <= 1'b0;
            misaligned <= 1'b0;
            bus_err    <= 1'b1;
            load_data  <= '0;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
